// File: rtl/letter_stream_pkg.sv
// Shared types and character constants for the one-letter-per-cycle character stream.
package letter_stream_pkg;

  typedef logic [7:0] char_t;

  localparam char_t CHAR_LF  = 8'h0A;
  localparam char_t CHAR_NUL = 8'h00;

  typedef enum logic [0:0] {
    COLLECT,
    HOLD
  } rx_state_t;

endpackage

// File: rtl/letter_line_buffer.sv
// Line storage: MAX_LEN x 8 register file, one write port, one combinational read port.
module letter_line_buffer
  import letter_stream_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned AW     = $clog2(MAX_LEN)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  char_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output char_t         rdata_o
);

  // Contents are don't-care after reset, so the array carries no reset.
  char_t mem_q [MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/letter_line_receiver.sv
// Collects a character stream into a line buffer up to a terminator, holds the line for
// random-access readout and flags whether it equals a parameterised expected string.
module letter_line_receiver
  import letter_stream_pkg::*;
#(
  parameter int unsigned               MAX_LEN    = 16,
  parameter char_t                     TERM       = CHAR_LF,
  parameter int unsigned               EXPECT_LEN = 11,
  parameter logic [8*EXPECT_LEN-1:0]   EXPECT     = "Hello World",
  localparam int unsigned              AW         = $clog2(MAX_LEN),
  localparam int unsigned              CW         = $clog2(MAX_LEN + 1)
) (
  input  logic          _clock,
  input  logic          _reset,
  input  logic          _enable,
  input  char_t         _letter,
  input  logic          _release,
  input  logic [AW-1:0] _rd_addr,
  output char_t         _rd_data,
  output logic          _line_ready,
  output logic [CW-1:0] _line_len,
  output logic          _match,
  output logic          _overflow,
  output logic [7:0]    _dropped
);

  localparam logic [CW-1:0] MaxLenC = CW'(MAX_LEN);
  localparam logic [CW-1:0] ExpLenC = CW'(EXPECT_LEN);

  rx_state_t     state_q;
  logic [CW-1:0] count_q;
  logic          match_run_q;
  logic          ovf_run_q;
  logic          line_ready_q;
  logic [CW-1:0] line_len_q;
  logic          match_q;
  logic          overflow_q;
  logic [7:0]    dropped_q;

  char_t exp_byte;
  char_t buf_rdata;
  logic  is_term;
  logic  buf_we;

  assign is_term = (_letter == TERM);
  assign buf_we  = (state_q == COLLECT) && _enable && !is_term && (count_q < MaxLenC);

  // Expected character at the current write position; first character sits in the MSB byte.
  always_comb begin
    exp_byte = CHAR_NUL;
    for (int i = 0; i < int'(EXPECT_LEN); i++) begin
      if (count_q == CW'(i)) begin
        exp_byte = EXPECT[8*(int'(EXPECT_LEN)-1-i) +: 8];
      end
    end
  end

  letter_line_buffer #(
    .MAX_LEN (MAX_LEN)
  ) u_buffer (
    .clk_i   (_clock),
    .we_i    (buf_we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (_letter),
    .raddr_i (_rd_addr),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q      <= COLLECT;
      count_q      <= '0;
      match_run_q  <= 1'b1;
      ovf_run_q    <= 1'b0;
      line_ready_q <= 1'b0;
      line_len_q   <= '0;
      match_q      <= 1'b0;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (_enable) begin
            if (is_term) begin
              // A terminator on an empty line is ignored.
              if (count_q != '0) begin
                state_q      <= HOLD;
                line_ready_q <= 1'b1;
                line_len_q   <= count_q;
                overflow_q   <= ovf_run_q;
                match_q      <= match_run_q && (count_q == ExpLenC) && !ovf_run_q;
              end
            end else if (count_q < MaxLenC) begin
              count_q     <= count_q + 1'b1;
              match_run_q <= match_run_q && (count_q < ExpLenC) && (_letter == exp_byte);
            end else begin
              ovf_run_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (_enable && (dropped_q != 8'hFF)) begin
            dropped_q <= dropped_q + 8'd1;
          end
          if (_release) begin
            state_q      <= COLLECT;
            count_q      <= '0;
            match_run_q  <= 1'b1;
            ovf_run_q    <= 1'b0;
            line_ready_q <= 1'b0;
            line_len_q   <= '0;
            match_q      <= 1'b0;
            overflow_q   <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign _rd_data    = (CW'(_rd_addr) < line_len_q) ? buf_rdata : CHAR_NUL;
  assign _line_ready = line_ready_q;
  assign _line_len   = line_len_q;
  assign _match      = match_q;
  assign _overflow   = overflow_q;
  assign _dropped    = dropped_q;

endmodule

// File: tb/tb_letter_line_receiver.sv
// Directed and randomized bench for letter_line_receiver against a queue-based line model.
module tb_letter_line_receiver;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic       rel     = 1'b0;
  logic [7:0] ltr     = 8'h00;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_data;
  logic       line_ready;
  logic [4:0] line_len;
  logic       match;
  logic       overflow;
  logic [7:0] dropped;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: plain queues of characters.
  byte unsigned m_line[$];
  byte unsigned m_held[$];
  byte unsigned stim[$];
  bit           m_hold;
  bit           m_ovf;
  bit           m_hovf;
  int           m_drop;

  always #5 clk = ~clk;

  letter_line_receiver dut (
    ._clock      (clk),
    ._reset      (rst_n),
    ._enable     (en),
    ._letter     (ltr),
    ._release    (rel),
    ._rd_addr    (rd_addr),
    ._rd_data    (rd_data),
    ._line_ready (line_ready),
    ._line_len   (line_len),
    ._match      (match),
    ._overflow   (overflow),
    ._dropped    (dropped)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_line.delete();
    m_held.delete();
    m_hold = 1'b0;
    m_ovf  = 1'b0;
    m_hovf = 1'b0;
    m_drop = 0;
  endfunction

  function automatic bit m_match();
    string s = "Hello World";
    if (!m_hold || m_hovf || m_held.size() != 11) return 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (m_held[i] != s[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void m_step(input bit e, input byte unsigned l, input bit r);
    if (!m_hold) begin
      if (e) begin
        if (l == 8'h0A) begin
          if (m_line.size() > 0) begin
            m_hold = 1'b1;
            m_held = m_line;
            m_hovf = m_ovf;
            m_line.delete();
          end
        end else if (m_line.size() < 16) begin
          m_line.push_back(l);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end else begin
      if (e && m_drop < 255) m_drop++;
      if (r) begin
        m_hold = 1'b0;
        m_held.delete();
        m_ovf  = 1'b0;
        m_hovf = 1'b0;
      end
    end
  endfunction

  function automatic logic [7:0] m_rd(input int a);
    if (m_hold && a < m_held.size()) return m_held[a];
    return 8'h00;
  endfunction

  task automatic check_model(input string tag);
    int a;
    a = $urandom_range(0, 15);
    rd_addr = 4'(a);
    #1;
    check_eq({tag, ".ready"}, 32'(line_ready), 32'(m_hold));
    check_eq({tag, ".len"}, 32'(line_len), m_hold ? m_held.size() : 0);
    check_eq({tag, ".match"}, 32'(match), 32'(m_match()));
    check_eq({tag, ".ovf"}, 32'(overflow), 32'(m_hold && m_hovf));
    check_eq({tag, ".drop"}, 32'(dropped), m_drop);
    check_eq({tag, ".rd"}, 32'(rd_data), 32'(m_rd(a)));
  endtask

  task automatic step(input bit e, input byte unsigned l, input bit r, input string tag);
    en  = e;
    ltr = l;
    rel = r;
    @(posedge clk);
    m_step(e, l, r);
    #1;
    en  = 1'b0;
    rel = 1'b0;
    check_model(tag);
  endtask

  task automatic send_line(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, tag);
    step(1'b1, 8'h0A, 1'b0, tag);
  endtask

  task automatic check_rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    #1;
    check_eq(tag, 32'(rd_data), 32'(exp));
  endtask

  // Asserts reset between edges and checks that outputs clear without waiting for a clock.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_eq({tag, ".ready"}, 32'(line_ready), 0);
    check_eq({tag, ".len"}, 32'(line_len), 0);
    check_eq({tag, ".match"}, 32'(match), 0);
    check_eq({tag, ".ovf"}, 32'(overflow), 0);
    check_eq({tag, ".drop"}, 32'(dropped), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic refill();
    string hw = "Hello World";
    int    kind;
    int    n;
    kind = $urandom_range(0, 2);
    if (kind == 0) begin
      for (int i = 0; i < 11; i++) stim.push_back(hw[i]);
    end else if (kind == 1) begin
      n = $urandom_range(0, 10);
      for (int i = 0; i < 11; i++) stim.push_back(i == n ? 8'h41 + 8'($urandom_range(0, 3)) : hw[i]);
    end else begin
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) stim.push_back(8'h41 + 8'($urandom_range(0, 3)));
    end
    stim.push_back(8'h0A);
  endtask

  initial begin
    bit           e;
    bit           r;
    byte unsigned l;

    m_reset();
    #2;
    do_reset("rst0");

    // 1: matching line
    send_line("Hello World", "t1");
    check_eq("t1.ready", 32'(line_ready), 1);
    check_eq("t1.len", 32'(line_len), 11);
    check_eq("t1.match", 32'(match), 1);
    check_eq("t1.ovf", 32'(overflow), 0);
    check_rd(4'd4, 8'h6F, "t1.rd4");
    check_rd(4'd11, 8'h00, "t1.rd11");
    step(1'b0, 8'h00, 1'b1, "t1.rel");

    // 2: near misses
    send_line("Hello Worle", "t2a");
    check_eq("t2a.len", 32'(line_len), 11);
    check_eq("t2a.match", 32'(match), 0);
    step(1'b0, 8'h00, 1'b1, "t2a.rel");
    send_line("Hello World!", "t2b");
    check_eq("t2b.len", 32'(line_len), 12);
    check_eq("t2b.match", 32'(match), 0);
    step(1'b0, 8'h00, 1'b1, "t2b.rel");

    // 3: overflow
    for (int i = 0; i < 20; i++) step(1'b1, 8'h41, 1'b0, "t3");
    step(1'b1, 8'h0A, 1'b0, "t3");
    check_eq("t3.len", 32'(line_len), 16);
    check_eq("t3.ovf", 32'(overflow), 1);
    check_eq("t3.match", 32'(match), 0);
    check_rd(4'd15, 8'h41, "t3.rd15");

    // 4: drops while holding, release with the third
    step(1'b1, 8'h61, 1'b0, "t4");
    step(1'b1, 8'h0A, 1'b0, "t4");
    step(1'b1, 8'h62, 1'b1, "t4");
    check_eq("t4.drop", 32'(dropped), 3);
    check_eq("t4.ready", 32'(line_ready), 0);
    send_line("Hello World", "t4b");
    check_eq("t4b.match", 32'(match), 1);
    check_eq("t4b.drop", 32'(dropped), 3);
    step(1'b0, 8'h00, 1'b1, "t4.rel");

    // 5: empty line ignored
    step(1'b1, 8'h0A, 1'b0, "t5");
    check_eq("t5.ready", 32'(line_ready), 0);
    send_line("Hello World", "t5b");
    check_eq("t5b.match", 32'(match), 1);
    step(1'b0, 8'h00, 1'b1, "t5.rel");

    // 6: reset mid-line, then saturating drop counter
    step(1'b1, 8'h48, 1'b0, "t6");
    step(1'b1, 8'h65, 1'b0, "t6");
    step(1'b1, 8'h6C, 1'b0, "t6");
    do_reset("t6.rst");
    send_line("Hello World", "t6b");
    check_eq("t6b.match", 32'(match), 1);
    check_eq("t6b.len", 32'(line_len), 11);
    for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, "t6d");
    check_eq("t6d.drop", 32'(dropped), 255);

    // Randomized traffic
    do_reset("rnd.rst");
    stim.delete();
    for (int c = 0; c < 3000; c++) begin
      if (stim.size() == 0) refill();
      e = ($urandom_range(0, 3) != 0);
      r = m_hold ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      l = e ? stim.pop_front() : 8'($urandom_range(0, 255));
      step(e, l, r, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
